// File: rtl/axi_raddr_ch.sv
// rtl/axi_raddr_ch.sv - AR channel stage: segment bounds check, address translation, outstanding-read cap
module axi_raddr_ch #(
   parameter int MAX_OUT = 4,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    in_arid,
   input  logic [AW-1:0] in_araddr,
   input  logic [7:0]    in_arlen,
   input  logic [2:0]    in_arsize,
   input  logic [1:0]    in_arburst,
   input  logic          in_arvalid,
   output logic          out_arready,
   input  logic [AW-1:0] in_seg_base,
   input  logic [AW:0]   in_seg_limit,
   output logic [3:0]    out_marid,
   output logic [AW-1:0] out_maraddr,
   output logic [7:0]    out_marlen,
   output logic [2:0]    out_marsize,
   output logic [1:0]    out_marburst,
   output logic          out_marvalid,
   input  logic          in_marready,
   input  logic          in_rdone,
   output logic          out_err_valid,
   output logic [3:0]    out_err_id,
   output logic [1:0]    out_err_code,
   input  logic          in_err_ack,
   output logic [3:0]    out_outstanding
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] MAX_OUT_C  = 4'(MAX_OUT);

   logic [1:0]    state;
   logic [3:0]    outstanding;

   logic [3:0]    id_q;
   logic [AW-1:0] addr_q;
   logic [7:0]    len_q;
   logic [2:0]    size_q;
   logic [1:0]    burst_q;

   logic [16:0]   bytes;
   logic [AW:0]   end_addr;
   logic [AW-1:0] last_byte;
   logic          page_cross;
   logic [1:0]    chk_code;
   logic [AW-1:0] phys_addr;

   logic          mar_hs;
   logic          rdone_eff;

   assign out_outstanding = outstanding;
   assign out_arready     = !reset && (state == S_IDLE) && (outstanding < MAX_OUT_C);

   assign mar_hs    = out_marvalid && in_marready;
   assign rdone_eff = in_rdone && (outstanding != 4'd0);

   // End address keeps the carry bit so a burst ending exactly at 2^AW still compares correctly.
   always_comb begin
      bytes      = ({9'd0, len_q} + 17'd1) << size_q;
      end_addr   = {1'b0, addr_q} + (AW+1)'(bytes);
      last_byte  = end_addr[AW-1:0] - AW'(1);
      page_cross = |((last_byte ^ addr_q) >> 12);
      phys_addr  = addr_q + in_seg_base;
      chk_code   = 2'd0;
      if (size_q > 3'd5) begin
         chk_code = 2'd3;
      end else if (end_addr > in_seg_limit) begin
         chk_code = 2'd1;
      end else if ((burst_q == BURST_INCR) && page_cross) begin
         chk_code = 2'd2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         outstanding   <= 4'd0;
         id_q          <= 4'd0;
         addr_q        <= '0;
         len_q         <= 8'd0;
         size_q        <= 3'd0;
         burst_q       <= 2'd0;
         out_marid     <= 4'd0;
         out_maraddr   <= '0;
         out_marlen    <= 8'd0;
         out_marsize   <= 3'd0;
         out_marburst  <= 2'd0;
         out_marvalid  <= 1'b0;
         out_err_valid <= 1'b0;
         out_err_id    <= 4'd0;
         out_err_code  <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_arvalid && out_arready) begin
                  id_q    <= in_arid;
                  addr_q  <= in_araddr;
                  len_q   <= in_arlen;
                  size_q  <= in_arsize;
                  burst_q <= in_arburst;
                  state   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (chk_code != 2'd0) begin
                  out_err_valid <= 1'b1;
                  out_err_id    <= id_q;
                  out_err_code  <= chk_code;
                  state         <= S_ERR;
               end else begin
                  out_marid    <= id_q;
                  out_maraddr  <= phys_addr;
                  out_marlen   <= len_q;
                  out_marsize  <= size_q;
                  out_marburst <= burst_q;
                  out_marvalid <= 1'b1;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (in_marready) begin
                  out_marvalid <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            S_ERR: begin
               if (in_err_ack) begin
                  out_err_valid <= 1'b0;
                  out_err_id    <= 4'd0;
                  out_err_code  <= 2'd0;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Issue and completion in the same cycle cancel out.
         if (mar_hs && !rdone_eff) begin
            outstanding <= outstanding + 4'd1;
         end else if (!mar_hs && rdone_eff) begin
            outstanding <= outstanding - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_raddr_ch.sv
// tb/tb_axi_raddr_ch.sv - table-driven and scoreboard bench for axi_raddr_ch
module tb_axi_raddr_ch;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_arid;
   logic [31:0] in_araddr;
   logic [7:0]  in_arlen;
   logic [2:0]  in_arsize;
   logic [1:0]  in_arburst;
   logic        in_arvalid;
   logic        out_arready;
   logic [31:0] in_seg_base;
   logic [32:0] in_seg_limit;
   logic [3:0]  out_marid;
   logic [31:0] out_maraddr;
   logic [7:0]  out_marlen;
   logic [2:0]  out_marsize;
   logic [1:0]  out_marburst;
   logic        out_marvalid;
   logic        in_marready;
   logic        in_rdone;
   logic        out_err_valid;
   logic [3:0]  out_err_id;
   logic [1:0]  out_err_code;
   logic        in_err_ack;
   logic [3:0]  out_outstanding;

   always #5 clk = ~clk;

   axi_raddr_ch #(.MAX_OUT(4), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .in_arid(in_arid), .in_araddr(in_araddr), .in_arlen(in_arlen),
      .in_arsize(in_arsize), .in_arburst(in_arburst), .in_arvalid(in_arvalid),
      .out_arready(out_arready),
      .in_seg_base(in_seg_base), .in_seg_limit(in_seg_limit),
      .out_marid(out_marid), .out_maraddr(out_maraddr), .out_marlen(out_marlen),
      .out_marsize(out_marsize), .out_marburst(out_marburst),
      .out_marvalid(out_marvalid), .in_marready(in_marready),
      .in_rdone(in_rdone),
      .out_err_valid(out_err_valid), .out_err_id(out_err_id),
      .out_err_code(out_err_code), .in_err_ack(in_err_ack),
      .out_outstanding(out_outstanding)
   );

   typedef struct {
      logic        is_err;
      logic [3:0]  id;
      logic [31:0] maraddr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [1:0]  code;
   } sb_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] base;
      logic [32:0] limit;
      logic [1:0]  code;
      logic [31:0] maraddr;
   } vec_t;

   sb_t  sb[$];
   int   checks = 0;
   int   errors = 0;

   logic        pend = 1'b0;
   logic [49:0] held = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: compares every forwarded burst and every acked error report.
   always @(negedge clk) begin
      sb_t e;
      if (reset) begin
         pend <= 1'b0;
      end else begin
         if (pend)
            check("mar_hold", {out_marvalid, out_marid, out_maraddr, out_marlen, out_marsize, out_marburst}, held);
         pend <= out_marvalid && !in_marready;
         held <= {out_marvalid, out_marid, out_maraddr, out_marlen, out_marsize, out_marburst};
         if (out_marvalid && in_marready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mar: got id 0x%0h, expected no request", out_marid);
            end else begin
               e = sb.pop_front();
               check("mar_kind", 0, e.is_err);
               check("mar_id", out_marid, e.id);
               check("mar_addr", out_maraddr, e.maraddr);
               check("mar_len", out_marlen, e.len);
               check("mar_size", out_marsize, e.size);
               check("mar_burst", out_marburst, e.burst);
            end
         end
         if (out_err_valid && in_err_ack) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_err: got id 0x%0h, expected no error", out_err_id);
            end else begin
               e = sb.pop_front();
               check("err_kind", 1, e.is_err);
               check("err_id", out_err_id, e.id);
               check("err_code", out_err_code, e.code);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [1:0] code, input logic [31:0] maraddr);
      sb_t e;
      int n;
      e.is_err = (code != 2'd0); e.id = id; e.maraddr = maraddr;
      e.len = len; e.size = size; e.burst = burst; e.code = code;
      step();
      sb.push_back(e);
      in_arid = id; in_araddr = addr; in_arlen = len; in_arsize = size; in_arburst = burst;
      in_arvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (out_arready) begin
            step();
            in_arvalid = 1'b0;
            break;
         end
         n++;
         if (n > 200) begin
            check("arready_timeout", out_arready, 1);
            in_arvalid = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, sb.size(), 0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_marvalid(input string name);
      int n = 0;
      while (!out_marvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_marvalid"}, out_marvalid, 1);
   endtask

   task automatic rdone_pulse();
      step();
      in_rdone = 1'b1;
      step();
      in_rdone = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   vec_t vt[15];

   initial begin
      logic [49:0] snap;
      vt[0]  = '{4'd1,  32'h0000_0100, 8'd3,   3'd2, 2'b01, 32'h8000_0000, 33'h0_0001_0000, 2'd0, 32'h8000_0100};
      vt[1]  = '{4'd5,  32'h0000_0FF0, 8'd7,   3'd2, 2'b01, 32'h8000_0000, 33'h0_0000_1000, 2'd1, 32'h0};
      vt[2]  = '{4'd6,  32'h0000_0FF8, 8'd3,   3'd2, 2'b01, 32'h8000_0000, 33'h0_0001_0000, 2'd2, 32'h0};
      vt[3]  = '{4'd7,  32'h0000_0FF8, 8'd3,   3'd2, 2'b00, 32'h8000_0000, 33'h0_0001_0000, 2'd0, 32'h8000_0FF8};
      vt[4]  = '{4'd1,  32'h0000_0000, 8'd0,   3'd6, 2'b01, 32'h8000_0000, 33'h0_0001_0000, 2'd3, 32'h0};
      vt[5]  = '{4'd2,  32'h0000_0FF0, 8'd7,   3'd7, 2'b01, 32'h8000_0000, 33'h0_0000_1000, 2'd3, 32'h0};
      vt[6]  = '{4'd4,  32'h0000_0FF8, 8'd3,   3'd2, 2'b01, 32'h8000_0000, 33'h0_0000_1000, 2'd1, 32'h0};
      vt[7]  = '{4'd8,  32'h0000_0FE0, 8'd7,   3'd2, 2'b01, 32'h8000_0000, 33'h0_0000_1000, 2'd0, 32'h8000_0FE0};
      vt[8]  = '{4'd9,  32'h0000_0FF8, 8'd3,   3'd2, 2'b10, 32'h8000_0000, 33'h0_0001_0000, 2'd0, 32'h8000_0FF8};
      vt[9]  = '{4'd10, 32'h0000_0000, 8'd255, 3'd5, 2'b01, 32'h8000_0000, 33'h0_0001_0000, 2'd2, 32'h0};
      vt[10] = '{4'd11, 32'h0000_0000, 8'd255, 3'd5, 2'b00, 32'h8000_0000, 33'h0_0001_0000, 2'd0, 32'h8000_0000};
      vt[11] = '{4'd12, 32'h0000_1000, 8'd0,   3'd0, 2'b01, 32'hFFFF_F000, 33'h0_0000_2000, 2'd0, 32'h0000_0000};
      vt[12] = '{4'd13, 32'hFFFF_FFF0, 8'd3,   3'd2, 2'b01, 32'h0000_0000, 33'h1_0000_0000, 2'd0, 32'hFFFF_FFF0};
      vt[13] = '{4'd14, 32'hFFFF_FFF0, 8'd4,   3'd2, 2'b01, 32'h0000_0000, 33'h1_0000_0000, 2'd1, 32'h0};
      vt[14] = '{4'd15, 32'h0000_0FFC, 8'd0,   3'd2, 2'b01, 32'h8000_0000, 33'h0_0001_0000, 2'd0, 32'h8000_0FFC};

      reset = 1'b1; in_arvalid = 1'b0; in_arid = '0; in_araddr = '0; in_arlen = '0;
      in_arsize = '0; in_arburst = '0; in_seg_base = 32'h8000_0000; in_seg_limit = 33'h1_0000;
      in_marready = 1'b1; in_rdone = 1'b0; in_err_ack = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_arready", out_arready, 0);
      check("rst_marvalid", out_marvalid, 0);
      check("rst_err_valid", out_err_valid, 0);
      check("rst_outstanding", out_outstanding, 0);
      check("rst_maraddr", out_maraddr, 0);
      check("rst_err_code", out_err_code, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_arready", out_arready, 1);

      // First-request latency: accepted at N, marvalid visible at N+2.
      step();
      sb.push_back('{1'b0, 4'd3, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 2'd0});
      in_arid = 4'd3; in_araddr = 32'h100; in_arlen = 8'd3; in_arsize = 3'd2; in_arburst = 2'b01;
      in_arvalid = 1'b1;
      @(negedge clk);
      check("lat_arready", out_arready, 1);
      step();
      in_arvalid = 1'b0;
      @(negedge clk);
      check("lat_n1_marvalid", out_marvalid, 0);
      @(negedge clk);
      check("lat_n2_marvalid", out_marvalid, 1);
      wait_drain("lat");
      check("lat_outstanding", out_outstanding, 1);
      rdone_pulse();
      @(negedge clk);
      check("lat_rdone", out_outstanding, 0);

      for (int i = 0; i < 15; i++) begin
         step();
         in_seg_base = vt[i].base;
         in_seg_limit = vt[i].limit;
         send_ar(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].code, vt[i].maraddr);
         wait_drain($sformatf("vec%0d", i));
         check($sformatf("vec%0d_outstanding", i), out_outstanding, (vt[i].code == 2'd0) ? 1 : 0);
         if (vt[i].code == 2'd0) begin
            rdone_pulse();
            @(negedge clk);
            check($sformatf("vec%0d_rdone", i), out_outstanding, 0);
         end
      end

      // Held error report until ack, then arready the following cycle.
      step();
      in_seg_base = 32'h8000_0000; in_seg_limit = 33'h1000; in_err_ack = 1'b0;
      send_ar(4'd9, 32'h0FF0, 8'd7, 3'd2, 2'b01, 2'd1, 32'h0);
      repeat (4) @(negedge clk);
      check("err_hold_valid", out_err_valid, 1);
      check("err_hold_id", out_err_id, 9);
      check("err_hold_code", out_err_code, 1);
      check("err_hold_arready", out_arready, 0);
      check("err_hold_marvalid", out_marvalid, 0);
      step();
      in_err_ack = 1'b1;
      step();
      @(negedge clk);
      check("err_ack_valid", out_err_valid, 0);
      check("err_ack_arready", out_arready, 1);
      check("err_ack_sb", sb.size(), 0);
      check("err_outstanding", out_outstanding, 0);

      // Throttle at MAX_OUT with no completions.
      step();
      in_seg_limit = 33'h1_0000; in_marready = 1'b1;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send_ar(4'(i + 1), 32'(i * 64), 8'd3, 3'd2, 2'b01, 2'd0, 32'h8000_0000 + 32'(i * 64));
         end
         begin
            repeat (40) @(negedge clk);
            check("thr_outstanding", out_outstanding, 4);
            check("thr_arready", out_arready, 0);
            check("thr_pending", sb.size(), 1);
            check("thr_marvalid", out_marvalid, 0);
            rdone_pulse();
         end
      join
      wait_drain("thr");
      check("thr_refill", out_outstanding, 4);
      for (int i = 0; i < 4; i++) rdone_pulse();
      @(negedge clk);
      check("thr_empty", out_outstanding, 0);

      // Backpressure stability, then simultaneous issue and completion.
      send_ar(4'd1, 32'h0, 8'd0, 3'd0, 2'b01, 2'd0, 32'h8000_0000);
      wait_drain("bp1");
      send_ar(4'd2, 32'h40, 8'd1, 3'd1, 2'b01, 2'd0, 32'h8000_0040);
      wait_drain("bp2");
      check("bp_outstanding2", out_outstanding, 2);
      step();
      in_marready = 1'b0;
      send_ar(4'd6, 32'h200, 8'd15, 3'd3, 2'b10, 2'd0, 32'h8000_0200);
      wait_marvalid("bp");
      snap = {out_marvalid, out_marid, out_maraddr, out_marlen, out_marsize, out_marburst};
      repeat (10) @(negedge clk);
      check("bp_stable", {out_marvalid, out_marid, out_maraddr, out_marlen, out_marsize, out_marburst}, snap);
      step();
      in_marready = 1'b1; in_rdone = 1'b1;
      step();
      in_rdone = 1'b0;
      @(negedge clk);
      check("bp_simul_outstanding", out_outstanding, 2);
      check("bp_simul_marvalid", out_marvalid, 0);
      check("bp_sb", sb.size(), 0);
      rdone_pulse();
      rdone_pulse();
      @(negedge clk);
      check("bp_zero", out_outstanding, 0);
      rdone_pulse();
      @(negedge clk);
      check("bp_rdone_at_zero", out_outstanding, 0);

      // Reset while a request is held in ISSUE.
      send_ar(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 2'd0, 32'h8000_0000);
      wait_drain("rst1");
      check("rst_pre_outstanding", out_outstanding, 1);
      step();
      in_marready = 1'b0;
      send_ar(4'd2, 32'h80, 8'd0, 3'd2, 2'b01, 2'd0, 32'h8000_0080);
      wait_marvalid("rst");
      step();
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_arready", out_arready, 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_marvalid", out_marvalid, 0);
      check("rst_mid_outstanding", out_outstanding, 0);
      check("rst_mid_err_valid", out_err_valid, 0);
      sb.delete();
      step();
      reset = 1'b0;
      in_marready = 1'b1;
      @(negedge clk);
      check("rst_rel_arready", out_arready, 1);
      check("rst_rel_marvalid", out_marvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
